// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: datapath widths, writeback FSM states and load sizes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word lane from a little-endian memory word and extends it.
module load_align
    import cpu_types_pkg::*;
(
    input  word_t      word_i,
    input  logic [1:0] addr_lo_i,
    input  logic [1:0] size_i,
    input  logic       signed_i,
    output word_t      data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
    // Half loads ignore addr_lo_i[0]; only the upper/lower half is selectable.
    assign half_lane = word_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = word_i;
        case (size_i)
            LD_BYTE: data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            LD_HALF: data_o = {{16{signed_i & half_lane[15]}}, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: commits ALU results in one cycle, holds loads until dhit, drives the RF port.
module wb_stage
    import cpu_types_pkg::*;
(
    input  logic       clk,
    input  logic       nRst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_wen,
    input  regbits_t   in_wsel,
    input  word_t      in_res,
    input  logic       in_is_load,
    input  logic [1:0] in_ld_size,
    input  logic       in_ld_signed,
    input  logic [1:0] in_addr_lo,
    input  logic       dhit,
    input  word_t      dload,
    input  logic       flush,
    output logic       wen,
    output regbits_t   wsel,
    output word_t      wdat,
    output logic       pend_valid,
    output regbits_t   pend_wsel
);

    wb_state_t  state_q, state_d;
    regbits_t   wsel_q, wsel_d;
    word_t      wdat_q, wdat_d;
    logic       wen_q, wen_d;
    logic       pend_valid_q, pend_valid_d;
    logic       qual_q, qual_d;
    logic [1:0] size_q, size_d;
    logic       signed_q, signed_d;
    logic [1:0] addr_lo_q, addr_lo_d;
    logic       transfer;
    word_t      aligned;

    load_align u_load_align (
        .word_i    (dload),
        .addr_lo_i (addr_lo_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .data_o    (aligned)
    );

    assign in_ready = (state_q != WAIT_MEM);
    assign transfer = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        wsel_d    = wsel_q;
        wdat_d    = wdat_q;
        wen_d     = 1'b0;
        qual_d    = qual_q;
        size_d    = size_q;
        signed_d  = signed_q;
        addr_lo_d = addr_lo_q;
        case (state_q)
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (transfer) begin
                    wsel_d = in_wsel;
                    // Writes to x0 still flow through COMMIT but never assert wen.
                    qual_d = in_wen && (in_wsel != '0);
                    if (in_is_load) begin
                        state_d   = WAIT_MEM;
                        size_d    = in_ld_size;
                        signed_d  = in_ld_signed;
                        addr_lo_d = in_addr_lo;
                    end else begin
                        state_d = COMMIT;
                        wdat_d  = in_res;
                        wen_d   = qual_d;
                    end
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (dhit) begin
                    state_d = COMMIT;
                    wdat_d  = aligned;
                    wen_d   = qual_q;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_valid_d = (state_d == WAIT_MEM) || ((state_d == COMMIT) && wen_d);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            wsel_q       <= '0;
            wdat_q       <= '0;
            wen_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            qual_q       <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            addr_lo_q    <= '0;
        end else begin
            state_q      <= state_d;
            wsel_q       <= wsel_d;
            wdat_q       <= wdat_d;
            wen_q        <= wen_d;
            pend_valid_q <= pend_valid_d;
            qual_q       <= qual_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            addr_lo_q    <= addr_lo_d;
        end
    end

    assign wen        = wen_q;
    assign wsel       = wsel_q;
    assign wdat       = wdat_q;
    assign pend_valid = pend_valid_q;
    assign pend_wsel  = wsel_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a negedge monitor checks them.
module tb_wb_stage;

    logic        clk;
    logic        nRst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [4:0]  in_wsel;
    logic [31:0] in_res;
    logic        in_is_load;
    logic [1:0]  in_ld_size;
    logic        in_ld_signed;
    logic [1:0]  in_addr_lo;
    logic        dhit;
    logic [31:0] dload;
    logic        flush;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        pend_valid;
    logic [4:0]  pend_wsel;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_pass;
    int   n_total;

    wb_stage dut (
        .clk          (clk),
        .nRst         (nRst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_wen       (in_wen),
        .in_wsel      (in_wsel),
        .in_res       (in_res),
        .in_is_load   (in_is_load),
        .in_ld_size   (in_ld_size),
        .in_ld_signed (in_ld_signed),
        .in_addr_lo   (in_addr_lo),
        .dhit         (dhit),
        .dload        (dload),
        .flush        (flush),
        .wen          (wen),
        .wsel         (wsel),
        .wdat         (wdat),
        .pend_valid   (pend_valid),
        .pend_wsel    (pend_wsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every committed write must match the oldest scoreboard entry, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (nRst === 1'b1 && wen === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wr_sel", {27'd0, wsel}, {27'd0, e.sel});
                    check("wr_dat", wdat, e.dat);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [4:0] sel, input logic [31:0] res, input logic we,
                         input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [1:0] lo, output int acc);
        int n;
        in_valid     = 1'b1;
        in_wsel      = sel;
        in_res       = res;
        in_wen       = we;
        in_is_load   = ld;
        in_ld_size   = sz;
        in_ld_signed = sg;
        in_addr_lo   = lo;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc        = cyc;
        in_valid   = 1'b0;
        in_is_load = 1'b0;
    endtask

    task automatic alu(input logic [4:0] sel, input logic [31:0] res, input logic we);
        int acc;
        issue(sel, res, we, 1'b0, 2'd0, 1'b0, 2'd0, acc);
        if (we && sel != 5'd0) sb.push_back('{sel, res, acc});
    endtask

    task automatic load(input logic [4:0] sel, input logic [1:0] sz, input logic sg,
                        input logic [1:0] lo, input logic [31:0] dl, input int waits,
                        input logic [31:0] exp_dat, input logic do_flush);
        int acc;
        issue(sel, 32'h0BAD_0BAD, 1'b1, 1'b1, sz, sg, lo, acc);
        dload = dl;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("wait_ready", {31'd0, in_ready}, 32'd0);
            check("wait_pend", {31'd0, pend_valid}, 32'd1);
            check("wait_pend_wsel", {27'd0, pend_wsel}, {27'd0, sel});
            @(posedge clk);
            #1;
        end
        dhit  = 1'b1;
        flush = do_flush;
        if (!do_flush && sel != 5'd0) sb.push_back('{sel, exp_dat, acc + waits + 1});
        @(negedge clk);
        check("hit_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        dhit  = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("post_ready", {31'd0, in_ready}, 32'd1);
        if (do_flush) begin
            check("flush_wen", {31'd0, wen}, 32'd0);
            check("flush_pend", {31'd0, pend_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        n_pass       = 0;
        n_total      = 0;
        nRst         = 1'b0;
        in_valid     = 1'b0;
        in_wen       = 1'b0;
        in_wsel      = '0;
        in_res       = '0;
        in_is_load   = 1'b0;
        in_ld_size   = '0;
        in_ld_signed = 1'b0;
        in_addr_lo   = '0;
        dhit         = 1'b0;
        dload        = '0;
        flush        = 1'b0;

        #2;
        check("rst_wen", {31'd0, wen}, 32'd0);
        check("rst_wdat", wdat, 32'd0);
        check("rst_wsel", {27'd0, wsel}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_pend", {31'd0, pend_valid}, 32'd0);
        check("rst_pend_wsel", {27'd0, pend_wsel}, 32'd0);
        repeat (3) @(posedge clk);
        #1 nRst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_wen", {31'd0, wen}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Back-to-back ALU writes, then a load straight out of COMMIT.
        alu(5'd3, 32'hDEAD_BEEF, 1'b1);
        alu(5'd4, 32'h0000_0001, 1'b1);
        load(5'd5, 2'd0, 1'b1, 2'd2, 32'h12F4_5678, 3, 32'hFFFF_FFF4, 1'b0);

        // x0 destination and in_wen = 0 both pass through COMMIT silently.
        alu(5'd0, 32'h5555_5555, 1'b1);
        @(negedge clk);
        check("x0_wen", {31'd0, wen}, 32'd0);
        check("x0_pend", {31'd0, pend_valid}, 32'd0);
        check("x0_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        alu(5'd9, 32'h7777_7777, 1'b0);
        @(negedge clk);
        check("nowen_wen", {31'd0, wen}, 32'd0);
        @(posedge clk);
        #1;

        load(5'd6,  2'd1, 1'b0, 2'd2, 32'h8001_ABCD, 0, 32'h0000_8001, 1'b0);
        load(5'd7,  2'd2, 1'b0, 2'd0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0);
        load(5'd8,  2'd1, 1'b1, 2'd3, 32'h8001_ABCD, 0, 32'hFFFF_8001, 1'b0);
        load(5'd9,  2'd0, 1'b0, 2'd3, 32'h12F4_5678, 0, 32'h0000_0012, 1'b0);
        load(5'd10, 2'd0, 1'b1, 2'd0, 32'h12F4_5678, 2, 32'h0000_0078, 1'b0);
        load(5'd11, 2'd1, 1'b1, 2'd0, 32'h8001_ABCD, 0, 32'hFFFF_ABCD, 1'b0);

        // flush wins over a same-cycle dhit.
        load(5'd12, 2'd2, 1'b0, 2'd0, 32'h1111_2222, 1, 32'h0, 1'b1);

        // Asynchronous reset while a load waits; a later dhit must not write.
        issue(5'd13, 32'h0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, acc);
        dload = 32'hABAD_CAFE;
        @(negedge clk);
        check("rstw_ready_before", {31'd0, in_ready}, 32'd0);
        #2 nRst = 1'b0;
        #1;
        check("rstw_ready", {31'd0, in_ready}, 32'd1);
        check("rstw_pend", {31'd0, pend_valid}, 32'd0);
        check("rstw_pend_wsel", {27'd0, pend_wsel}, 32'd0);
        check("rstw_wen", {31'd0, wen}, 32'd0);
        @(posedge clk);
        #1 nRst = 1'b1;
        dhit = 1'b1;
        @(posedge clk);
        #1 dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstw_no_write", {31'd0, wen}, 32'd0);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
